// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and port count.
package mem_arbiter_pkg;

  localparam int ARB_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single memory port with registered strobes.
// Define MEM_ARB_RR_EN to replace fixed port-1 priority with round-robin on IDLE contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_read,
  input  logic             p0_write,
  input  logic [WIDTH-1:0] p0_addr,
  input  logic [WIDTH-1:0] p0_wdata,
  output logic [WIDTH-1:0] p0_rdata,
  output logic             p0_resp,
  input  logic             p1_read,
  input  logic             p1_write,
  input  logic [WIDTH-1:0] p1_addr,
  input  logic [WIDTH-1:0] p1_wdata,
  output logic [WIDTH-1:0] p1_rdata,
  output logic             p1_resp,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_resp,
  output arb_state_t       dbg_state
);

  // Handshake: a port requests while read or write is high and must hold its
  // request until px_resp; the memory holds mem_resp for one cycle per access
  // and the strobes stay steady from grant until that cycle.

  arb_state_t state;
  logic       p0_req;
  logic       p1_req;
  logic       pick1;
  logic       load;
  logic       load_p1;
  logic       done;

`ifdef MEM_ARB_RR_EN
  logic last_grant;
`endif

  assign p0_req = p0_read | p0_write;
  assign p1_req = p1_read | p1_write;

`ifdef MEM_ARB_RR_EN
  assign pick1 = p1_req && (!p0_req || !last_grant);
`else
  assign pick1 = p1_req;
`endif

  // Handoff only ever looks at the other port, so the port just served is
  // never regranted while its request is still high in the response cycle.
  always_comb begin
    load    = 1'b0;
    load_p1 = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        load    = p0_req | p1_req;
        load_p1 = pick1;
      end
      GRANT0: begin
        done    = mem_resp;
        load    = mem_resp & p1_req;
        load_p1 = 1'b1;
      end
      GRANT1: begin
        done    = mem_resp;
        load    = mem_resp & p0_req;
        load_p1 = 1'b0;
      end
      default: begin
        done = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else if (load) begin
      state     <= load_p1 ? GRANT1 : GRANT0;
      mem_addr  <= load_p1 ? p1_addr : p0_addr;
      mem_wdata <= load_p1 ? p1_wdata : p0_wdata;
      mem_write <= load_p1 ? p1_write : p0_write;
      mem_read  <= load_p1 ? (p1_read & ~p1_write) : (p0_read & ~p0_write);
`ifdef MEM_ARB_RR_EN
      last_grant <= load_p1;
`endif
    end else if (done) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  assign p0_resp   = mem_resp && (state == GRANT0);
  assign p1_resp   = mem_resp && (state == GRANT1);
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory responder model plus grant/response scoreboards.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int RW = 2 * W + 2;

  logic         clk;
  logic         rst_n;
  logic         p0_read, p0_write, p1_read, p1_write;
  logic [W-1:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [W-1:0] p0_rdata, p1_rdata;
  logic         p0_resp, p1_resp;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_read, mem_write, mem_resp;
  arb_state_t   dbg_state;

  mem_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_resp(p0_resp),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_resp(p1_resp),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  // req_q entry: {port, write, addr, wdata}; exp_q entry: {port, rdata}
  logic [RW-1:0] req_q[$];
  logic [W:0]    exp_q[$];

  function automatic logic [W-1:0] mem_model(input logic [W-1:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  task automatic expect_grant(input logic port, input logic wr, input logic [W-1:0] a,
                              input logic [W-1:0] wd);
    req_q.push_back({port, wr, a, wd});
  endtask

  task automatic expect_resp(input logic port, input logic [W-1:0] rd);
    exp_q.push_back({port, rd});
  endtask

  // ---------------- memory responder ----------------
  logic auto_mem = 1'b1;
  int   mem_lat  = 1;
  int   wait_cnt = 0;

  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_mem) begin
        mem_resp = 1'b0;
        if (rst_n && (mem_read || mem_write)) begin
          wait_cnt++;
          if (wait_cnt >= mem_lat) begin
            mem_resp  = 1'b1;
            mem_rdata = mem_model(mem_addr);
            wait_cnt  = 0;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  // ---------------- requesters drop the cycle after their resp ----------------
  initial forever begin
    @(negedge clk);
    if (p0_resp) begin
      @(posedge clk);
      #1;
      p0_read  = 1'b0;
      p0_write = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (p1_resp) begin
      @(posedge clk);
      #1;
      p1_read  = 1'b0;
      p1_write = 1'b0;
    end
  end

  // ---------------- monitors ----------------
  logic          prev_act  = 1'b0;
  logic          prev_done = 1'b0;
  logic [RW-1:0] cur_txn;
  logic [RW-1:0] exp_txn;
  logic [W:0]    exp_rsp;

  initial forever begin
    @(negedge clk);
    if (p0_resp || p1_resp) begin
      check("resp_onehot", {p0_resp, p1_resp} != 2'b11, 1'b1);
      if (exp_q.size() == 0) begin
        check("resp_unexpected", {p1_resp, p0_resp}, 2'b00);
      end else begin
        exp_rsp = exp_q.pop_front();
        check("resp_data", {p1_resp, p1_resp ? p1_rdata : p0_rdata}, exp_rsp);
      end
    end
  end

  initial forever begin
    logic act;
    @(negedge clk);
    act = mem_read | mem_write;
    if (act && (!prev_act || prev_done)) begin
      check("rw_exclusive", {mem_read, mem_write} != 2'b11, 1'b1);
      cur_txn = {dbg_state == GRANT1, mem_write, mem_addr, mem_wdata};
      if (req_q.size() == 0) begin
        check("grant_unexpected", act, 1'b0);
      end else begin
        exp_txn = req_q.pop_front();
        check("grant_txn", cur_txn, exp_txn);
      end
    end else if (act) begin
      check("grant_stable", {dbg_state == GRANT1, mem_write, mem_addr, mem_wdata}, cur_txn);
    end
    prev_act  = act;
    prev_done = act && mem_resp;
  end

  // ---------------- driver tasks ----------------
  task automatic issue0(input logic rd, input logic wr, input logic [W-1:0] a, input logic [W-1:0] wd);
    p0_read = rd; p0_write = wr; p0_addr = a; p0_wdata = wd;
  endtask

  task automatic issue1(input logic rd, input logic wr, input logic [W-1:0] a, input logic [W-1:0] wd);
    p1_read = rd; p1_write = wr; p1_addr = a; p1_wdata = wd;
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_q.size() == 0 && exp_q.size() == 0) break;
    end
    check({name, "_drain"}, k < 100, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_resp1(input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (p1_resp) break;
    end
    check({name, "_p1_resp_seen"}, k < 50, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    issue0(1'b0, 1'b0, '0, '0);
    issue1(1'b0, 1'b0, '0, '0);
    #12;
    check("rst_state", dbg_state, IDLE);
    check("rst_mem", {mem_read, mem_write, mem_addr, mem_wdata}, '0);
    check("rst_resp", {p0_resp, p1_resp}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    // single fetch read, one-cycle grant latency
    mem_lat = 1;
    @(posedge clk); #1;
    issue0(1'b1, 1'b0, 32'h100, 32'h0);
    expect_grant(1'b0, 1'b0, 32'h100, 32'h0);
    expect_resp(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    check("lat_not_yet", {mem_read, mem_write}, 2'b00);
    @(negedge clk);
    check("lat_read", {mem_read, mem_addr}, {1'b1, 32'h100});
    check("lat_resp", {p0_resp, p0_rdata}, {1'b1, 32'hDEADBEEF});
    @(negedge clk);
    check("idle_after", {dbg_state, mem_read}, {IDLE, 1'b0});
    wait_drain("t1");

    // contention: p1 wins, then direct handoff to p0
    @(posedge clk); #1;
    issue0(1'b1, 1'b0, 32'h300, 32'h0);
    issue1(1'b0, 1'b1, 32'h200, 32'h5A);
    expect_grant(1'b1, 1'b1, 32'h200, 32'h5A);
    expect_grant(1'b0, 1'b0, 32'h300, 32'h0);
    expect_resp(1'b1, ~32'h200);
    expect_resp(1'b0, ~32'h300);
    wait_resp1("t2");
    @(negedge clk);
    check("handoff_no_bubble", {dbg_state, mem_read, mem_addr}, {GRANT0, 1'b1, 32'h300});
    wait_drain("t2");

    // requester address changes while the grant waits on a slow memory
    mem_lat = 6;
    @(posedge clk); #1;
    issue1(1'b1, 1'b0, 32'h400, 32'h0);
    expect_grant(1'b1, 1'b0, 32'h400, 32'h0);
    expect_resp(1'b1, ~32'h400);
    @(posedge clk); #1;
    @(posedge clk); #1;
    p1_addr = 32'h4FC;
    wait_resp1("t3");
    check("addr_held", mem_addr, 32'h400);
    wait_drain("t3");
    mem_lat = 1;

    // reset two cycles into GRANT0 aborts without a response
    auto_mem = 1'b0;
    mem_resp = 1'b0;
    @(posedge clk); #1;
    issue0(1'b1, 1'b0, 32'h500, 32'h0);
    expect_grant(1'b0, 1'b0, 32'h500, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_grant", {dbg_state, mem_read}, {GRANT0, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_strobe", {mem_read, mem_write, mem_addr}, '0);
    check("rst_async_state", dbg_state, IDLE);
    issue0(1'b0, 1'b0, '0, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {dbg_state, mem_read, p0_resp}, {IDLE, 1'b0, 1'b0});

    // stray mem_resp in IDLE is ignored
    @(posedge clk); #1;
    mem_resp  = 1'b1;
    mem_rdata = 32'hCAFE;
    @(negedge clk);
    check("idle_resp_state", {dbg_state, mem_read, mem_write}, {IDLE, 2'b00});
    @(posedge clk); #1;
    mem_resp = 1'b0;
    @(negedge clk);
    check("idle_resp_after", dbg_state, IDLE);
    auto_mem = 1'b1;

    // read and write both high is a write
    @(posedge clk); #1;
    issue0(1'b1, 1'b1, 32'h600, 32'h1234);
    expect_grant(1'b0, 1'b1, 32'h600, 32'h1234);
    expect_resp(1'b0, ~32'h600);
    @(negedge clk);
    @(negedge clk);
    check("rw_is_write", {mem_write, mem_read}, 2'b10);
    wait_drain("t5");

    // solo p1 access, then a second contention
    @(posedge clk); #1;
    issue1(1'b1, 1'b0, 32'h700, 32'h0);
    expect_grant(1'b1, 1'b0, 32'h700, 32'h0);
    expect_resp(1'b1, ~32'h700);
    wait_drain("t6a");
    @(posedge clk); #1;
    issue0(1'b1, 1'b0, 32'h800, 32'h0);
    issue1(1'b1, 1'b0, 32'h900, 32'h0);
`ifdef MEM_ARB_RR_EN
    expect_grant(1'b0, 1'b0, 32'h800, 32'h0);
    expect_grant(1'b1, 1'b0, 32'h900, 32'h0);
    expect_resp(1'b0, ~32'h800);
    expect_resp(1'b1, ~32'h900);
`else
    expect_grant(1'b1, 1'b0, 32'h900, 32'h0);
    expect_grant(1'b0, 1'b0, 32'h800, 32'h0);
    expect_resp(1'b1, ~32'h900);
    expect_resp(1'b0, ~32'h800);
`endif
    wait_drain("t6b");

    check("final_idle", dbg_state, IDLE);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
